// File: rtl/iq_quarta_ctrl_if.sv
// Purpose: bundles the configuration, control, sample-strobe and coefficient signals of the fs/4 mixer sequencer.
// Latency: none; this is wiring only.
// Backpressure: cfg_valid/cfg_ready handshake; the sample path has no backpressure.
// Ports: master = sample-rate control side (drives cfg/start/stop/s_valid),
//        slave  = iq_quarta_ctrl (drives cfg_ready, ik/qk, coef_valid, index, busy, done).
interface iq_quarta_ctrl_if #(
    parameter int LEN_W = 16
);
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic                    cfg_dir;
    logic [1:0]              cfg_phase;
    logic [LEN_W-1:0]        cfg_len;
    logic                    start;
    logic                    stop;
    logic                    s_valid;
    logic signed [1:0]       ik;
    logic signed [1:0]       qk;
    logic                    coef_valid;
    logic [1:0]              index;
    logic                    busy;
    logic                    done;

    modport master (
        output cfg_valid, cfg_dir, cfg_phase, cfg_len, start, stop, s_valid,
        input  cfg_ready, ik, qk, coef_valid, index, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_dir, cfg_phase, cfg_len, start, stop, s_valid,
        output cfg_ready, ik, qk, coef_valid, index, busy, done
    );
endinterface

// File: rtl/iq_quarta_ctrl.sv
// Purpose: sequences the fs/4 quadrature mixer coefficients (ik, qk in {-1,0,+1}) for finite or continuous bursts.
// Latency: s_valid at edge k gives coef_valid/ik/qk at edge k+1; all outputs registered.
// Backpressure: cfg_ready is high only in IDLE, so config words offered mid-burst wait intact.
// Ports: clk, rst (async active-low), bus (iq_quarta_ctrl_if.slave).
module iq_quarta_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    iq_quarta_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                dir_q, dir_d;
    logic [1:0]          phase_q, phase_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    count_q, count_d;
    logic [1:0]          index_q, index_d;
    logic signed [1:0]   ik_q, ik_d;
    logic signed [1:0]   qk_q, qk_d;
    logic                coef_valid_q, coef_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                cfg_xfer;

    // cos(pi*n/2): 1, 0, -1, 0
    function automatic logic signed [1:0] ik_of(input logic [1:0] n);
        case (n)
            2'd0:    ik_of = 2'sb01;
            2'd2:    ik_of = 2'sb11;
            default: ik_of = 2'sb00;
        endcase
    endfunction

    // dir=0 uses -sin(pi*n/2), dir=1 uses +sin(pi*n/2)
    function automatic logic signed [1:0] qk_of(input logic [1:0] n, input logic dir);
        case (n)
            2'd1:    qk_of = dir ? 2'sb01 : 2'sb11;
            2'd3:    qk_of = dir ? 2'sb11 : 2'sb01;
            default: qk_of = 2'sb00;
        endcase
    endfunction

    assign cfg_xfer = bus.cfg_valid && cfg_ready_q;

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        phase_d      = phase_q;
        len_d        = len_q;
        count_d      = count_q;
        index_d      = index_q;
        ik_d         = 2'sb00;
        qk_d         = 2'sb00;
        coef_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Shadow capture and start share an edge: LOAD then sees the new word.
                if (cfg_xfer) begin
                    dir_d   = bus.cfg_dir;
                    phase_d = bus.cfg_phase;
                    len_d   = bus.cfg_len;
                end
                if (bus.start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else begin
                    index_d = phase_q;
                    count_d = len_q;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.s_valid) begin
                    coef_valid_d = 1'b1;
                    ik_d         = ik_of(index_q);
                    qk_d         = qk_of(index_q, dir_q);
                    index_d      = index_q + 2'd1;
                    // len=0 means continuous: the counter is left alone.
                    if (len_q != '0) begin
                        count_d = count_q - LEN_W'(1);
                        if (count_q == LEN_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                // Abort wins over completion; the strobed sample above still emits.
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state so they align with it.
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        cfg_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            phase_q      <= 2'd0;
            len_q        <= '0;
            count_q      <= '0;
            index_q      <= 2'd0;
            ik_q         <= 2'sb00;
            qk_q         <= 2'sb00;
            coef_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            phase_q      <= phase_d;
            len_q        <= len_d;
            count_q      <= count_d;
            index_q      <= index_d;
            ik_q         <= ik_d;
            qk_q         <= qk_d;
            coef_valid_q <= coef_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_ready_q  <= cfg_ready_d;
        end
    end

    assign bus.cfg_ready  = cfg_ready_q;
    assign bus.ik         = ik_q;
    assign bus.qk         = qk_q;
    assign bus.coef_valid = coef_valid_q;
    assign bus.index      = index_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_iq_quarta_ctrl.sv
// Purpose: randomized scoreboard bench for iq_quarta_ctrl against a table-level model of the fs/4 rotation.
// Latency: expects each accepted strobe to produce one coefficient one edge later.
// Backpressure: config words are held until cfg_ready is seen high.
module tb_iq_quarta_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    iq_quarta_ctrl_if #(.LEN_W(16)) bus ();

    iq_quarta_ctrl #(.LEN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ik_q[$];
    int exp_qk_q[$];
    int done_seen = 0;
    int sh_dir, sh_phase, sh_len;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Rotation e^{-/+ j*pi*n/2}: I = cos, Q = -/+ sin, evaluated from the angle.
    task automatic push_exp(input int dir, input int n);
        int c, s;
        case (n % 4)
            0: begin c = 1;  s = 0;  end
            1: begin c = 0;  s = 1;  end
            2: begin c = -1; s = 0;  end
            default: begin c = 0; s = -1; end
        endcase
        exp_ik_q.push_back(c);
        exp_qk_q.push_back(dir ? s : -s);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a coefficient.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.coef_valid) begin
                    if (exp_ik_q.size() == 0) begin
                        check("unexpected_coef", 1, 0);
                    end else begin
                        check("ik", int'(bus.ik), exp_ik_q.pop_front());
                        check("qk", int'(bus.qk), exp_qk_q.pop_front());
                    end
                end else begin
                    check("zero_between_samples", int'({bus.ik, bus.qk}), 0);
                end
                if (bus.done) done_seen++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!bus.cfg_ready && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) check("cfg_ready_timeout", 0, 1);
    endtask

    task automatic send_cfg(input int d, input int p, input int l);
        wait_ready();
        bus.cfg_dir   = d[0];
        bus.cfg_phase = p[1:0];
        bus.cfg_len   = l[15:0];
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        sh_dir = d; sh_phase = p; sh_len = l;
    endtask

    // Issues start (optionally with a config word on the same edge) and steps through LOAD.
    task automatic start_burst(input bit with_cfg, input int d, input int p, input int l);
        if (with_cfg) begin
            wait_ready();
            bus.cfg_dir   = d[0];
            bus.cfg_phase = p[1:0];
            bus.cfg_len   = l[15:0];
            bus.cfg_valid = 1'b1;
        end
        bus.start = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.cfg_valid = 1'b0;
        if (with_cfg) begin
            sh_dir = d; sh_phase = p; sh_len = l;
        end
        check("busy_in_load", int'(bus.busy), 1);
        check("cfg_ready_in_load", int'(bus.cfg_ready), 0);
        tick();
    endtask

    // gap_mode: 0 = back-to-back, 1 = every other cycle, 2 = random 0..2 idle cycles.
    task automatic run_samples(input int d, input int p, input int nsamp, input int gap_mode, input bit stop_last);
        for (int i = 0; i < nsamp; i++) begin
            int gaps;
            gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? ((i == 0) ? 0 : 1) : int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) begin
                bus.s_valid = 1'b0;
                bus.start   = $urandom_range(0, 1) == 1;
                check("index_hold", int'(bus.index), (p + i) % 4);
                tick();
                bus.start = 1'b0;
            end
            check("index", int'(bus.index), (p + i) % 4);
            bus.s_valid = 1'b1;
            if (stop_last && i == nsamp - 1) bus.stop = 1'b1;
            push_exp(d, p + i);
            tick();
            bus.s_valid = 1'b0;
            bus.stop    = 1'b0;
        end
    endtask

    // Called in the DONE cycle: a stray strobe there must not emit a coefficient.
    task automatic finish_finite(input int done_before);
        check("done_pulse_level", int'(bus.done), 1);
        check("busy_in_done", int'(bus.busy), 1);
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        check("done_clears", int'(bus.done), 0);
        check("busy_idle", int'(bus.busy), 0);
        check("cfg_ready_idle", int'(bus.cfg_ready), 1);
        tick();
        check("done_count", done_seen - done_before, 1);
        check("scoreboard_drained", exp_ik_q.size(), 0);
    endtask

    initial begin
        int db;
        rst           = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_dir   = 1'b0;
        bus.cfg_phase = 2'd0;
        bus.cfg_len   = 16'd0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.s_valid   = 1'b0;
        sh_dir = 0; sh_phase = 0; sh_len = 0;

        // Reset and idle
        repeat (3) tick();
        check("rst_coef_valid", int'(bus.coef_valid), 0);
        check("rst_ikqk", int'({bus.ik, bus.qk}), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_cfg_ready", int'(bus.cfg_ready), 0);
        check("rst_index", int'(bus.index), 0);
        rst = 1'b1;
        #2;
        check("cfg_ready_before_edge", int'(bus.cfg_ready), 0);
        tick();
        check("cfg_ready_first_edge", int'(bus.cfg_ready), 1);
        check("busy_after_reset", int'(bus.busy), 0);

        // Basic burst: dir=0, phase=0, len=8, back-to-back strobes
        db = done_seen;
        send_cfg(0, 0, 8);
        start_burst(0, 0, 0, 0);
        run_samples(sh_dir, sh_phase, 8, 0, 0);
        finish_finite(db);

        // Direction/phase with config and start on the same edge, every-other-cycle strobes
        db = done_seen;
        start_burst(1, 1, 2, 4);
        run_samples(sh_dir, sh_phase, 4, 1, 0);
        finish_finite(db);

        // Config gating: a word offered mid-burst waits for IDLE
        db = done_seen;
        send_cfg(0, 1, 6);
        start_burst(0, 0, 0, 0);
        bus.cfg_dir   = 1'b0;
        bus.cfg_phase = 2'd3;
        bus.cfg_len   = 16'd5;
        bus.cfg_valid = 1'b1;
        check("cfg_ready_in_run", int'(bus.cfg_ready), 0);
        run_samples(0, 1, 6, 2, 0);
        check("cfg_ready_in_done", int'(bus.cfg_ready), 0);
        tick();
        check("cfg_ready_first_idle", int'(bus.cfg_ready), 1);
        tick();
        bus.cfg_valid = 1'b0;
        sh_dir = 0; sh_phase = 3; sh_len = 5;
        check("gated_done_count", done_seen - db, 1);
        db = done_seen;
        start_burst(0, 0, 0, 0);
        run_samples(sh_dir, sh_phase, 5, 2, 0);
        finish_finite(db);

        // Continuous burst ended by stop together with the 11th strobe
        db = done_seen;
        start_burst(1, 1, 1, 0);
        run_samples(sh_dir, sh_phase, 11, 2, 1);
        tick();
        check("busy_after_stop", int'(bus.busy), 0);
        check("cfg_ready_after_stop", int'(bus.cfg_ready), 1);
        tick();
        check("no_done_on_stop", done_seen - db, 0);
        check("stop_scoreboard_drained", exp_ik_q.size(), 0);

        // Async reset mid-burst, then a burst on the default configuration
        send_cfg(1, 2, 8);
        start_burst(0, 0, 0, 0);
        run_samples(sh_dir, sh_phase, 3, 0, 0);
        #6;
        rst = 1'b0;
        #1;
        check("arst_coef_valid", int'(bus.coef_valid), 0);
        check("arst_ikqk", int'({bus.ik, bus.qk}), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_index", int'(bus.index), 0);
        check("arst_cfg_ready", int'(bus.cfg_ready), 0);
        check("arst_scoreboard_drained", exp_ik_q.size(), 0);
        exp_ik_q.delete();
        exp_qk_q.delete();
        sh_dir = 0; sh_phase = 0; sh_len = 0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        db = done_seen;
        start_burst(0, 0, 0, 0);
        run_samples(sh_dir, sh_phase, 12, 2, 1);
        tick();
        check("busy_after_default_stop", int'(bus.busy), 0);
        tick();
        check("default_cfg_no_done", done_seen - db, 0);
        check("final_scoreboard_drained", exp_ik_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
